// File: rtl/clk_gen_ds_ctrl.sv
// Sequencer for the clock generator + downsampler pair: applies each accepted select
// through a reset/load/release sequence and confirms the downsampled clock is running.
module clk_gen_ds_ctrl #(
  parameter int sel_width_p     = 8,
  parameter int default_sel_p   = 0,
  parameter int cg_rst_cycles_p = 5,
  parameter int ds_delay_p      = 10,
  parameter int lock_edges_p    = 4,
  parameter int timeout_p       = 1024
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   cfg_v_i,
  input  logic [sel_width_p-1:0] cfg_i,
  output logic                   cfg_ready_o,
  input  logic                   ds_clk_i,
  output logic [sel_width_p-1:0] select_o,
  output logic                   clk_reset_o,
  output logic                   ds_reset_o,
  output logic                   locked_o,
  output logic                   err_o,
  output logic                   done_o
);

  localparam int PhaseMax = (cg_rst_cycles_p > ds_delay_p) ? cg_rst_cycles_p : ds_delay_p;
  localparam int CW = $clog2(PhaseMax + 1);
  localparam int EW = $clog2(lock_edges_p + 1);
  localparam int TW = $clog2(timeout_p + 1);

  localparam logic [CW-1:0]          HoldLast   = CW'(cg_rst_cycles_p - 1);
  localparam logic [CW-1:0]          DelayLast  = CW'(ds_delay_p - 1);
  localparam logic [EW-1:0]          LockEdges  = EW'(lock_edges_p);
  localparam logic [TW-1:0]          Timeout    = TW'(timeout_p);
  localparam logic [sel_width_p-1:0] DefaultSel = sel_width_p'(default_sel_p);

  typedef enum logic [2:0] {IDLE, HOLD, LOAD, REL_CG, REL_DS, CHECK} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [EW-1:0]          edge_q, edge_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [sel_width_p-1:0] cfg_q, cfg_d;
  logic [sel_width_p-1:0] sel_q, sel_d;
  logic                   locked_q, locked_d;
  logic                   err_q, err_d;
  logic                   done_q, done_d;
  logic [2:0]             sync_q;
  logic                   ds_rise;

  // Bits 0..1 form the synchronizer; bit 2 holds the previous synced value for edge detection.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) sync_q <= '0;
    else            sync_q <= {sync_q[1:0], ds_clk_i};
  end

  assign ds_rise = sync_q[1] & ~sync_q[2];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= HOLD;
      cnt_q    <= '0;
      edge_q   <= '0;
      tmo_q    <= '0;
      cfg_q    <= DefaultSel;
      sel_q    <= DefaultSel;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      edge_q   <= edge_d;
      tmo_q    <= tmo_d;
      cfg_q    <= cfg_d;
      sel_q    <= sel_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    edge_d   = edge_q;
    tmo_d    = tmo_q;
    cfg_d    = cfg_q;
    sel_d    = sel_q;
    locked_d = locked_q;
    err_d    = err_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_v_i) begin
          cfg_d    = cfg_i;
          locked_d = 1'b0;
          err_d    = 1'b0;
          cnt_d    = '0;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        // Select is registered on the way into LOAD so it is stable for the whole LOAD cycle.
        if (cnt_q >= HoldLast) begin
          cnt_d   = '0;
          sel_d   = cfg_q;
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = REL_CG;
      end
      REL_CG: begin
        if (cnt_q >= DelayLast) begin
          cnt_d   = '0;
          state_d = REL_DS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REL_DS: begin
        edge_d  = '0;
        tmo_d   = '0;
        state_d = CHECK;
      end
      CHECK: begin
        if (ds_rise && (edge_q != LockEdges)) edge_d = edge_q + 1'b1;
        if (tmo_q != Timeout)                 tmo_d  = tmo_q + 1'b1;
        // Lock is tested first so a same-cycle lock beats the timeout.
        if (edge_d == LockEdges) begin
          locked_d = 1'b1;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (tmo_d == Timeout) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  assign cfg_ready_o = (state_q == IDLE);
  assign clk_reset_o = (state_q == HOLD) || (state_q == LOAD);
  assign ds_reset_o  = (state_q == HOLD) || (state_q == LOAD) || (state_q == REL_CG);
  assign select_o    = sel_q;
  assign locked_o    = locked_q;
  assign err_o       = err_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_clk_gen_ds_ctrl.sv
// Self-checking bench for clk_gen_ds_ctrl: a gated stand-in clock generator feeds ds_clk,
// and each sequence is judged against timing derived directly from the parameters.
`timescale 1ns/1ps
module tb_clk_gen_ds_ctrl;

  localparam int CG_RST     = 5;
  localparam int DSD        = 10;
  localparam int LOCK_EDGES = 4;
  localparam int TIMEOUT    = 1024;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       cfgV = 1'b0;
  logic [7:0] cfgI = 8'h00;
  logic       cfgReadyO;
  logic       dsClk = 1'b0;
  logic [7:0] selectO;
  logic       clkResetO;
  logic       dsResetO;
  logic       lockedO;
  logic       errO;
  logic       doneO;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int selBad = 0;
  logic [7:0] prevSel = 8'h00;

  bit dsRun = 1'b1;
  bit dsSelPeriod = 1'b0;
  int dsHalf = 4;
  int dsCnt = 0;
  int curHalf = 4;
  bit jitterCfg = 1'b0;
  int riseCyc[$];

  clk_gen_ds_ctrl #(
    .sel_width_p(8), .default_sel_p(0), .cg_rst_cycles_p(CG_RST),
    .ds_delay_p(DSD), .lock_edges_p(LOCK_EDGES), .timeout_p(TIMEOUT)
  ) dut (
    .clk_i(clk), .reset_n_i(resetN), .cfg_v_i(cfgV), .cfg_i(cfgI),
    .cfg_ready_o(cfgReadyO), .ds_clk_i(dsClk), .select_o(selectO),
    .clk_reset_o(clkResetO), .ds_reset_o(dsResetO), .locked_o(lockedO),
    .err_o(errO), .done_o(doneO)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in generator: held low while the downsampler is in reset, period chosen by select in sweep mode.
  always @(negedge clk) begin
    curHalf = dsSelPeriod ? (2 + int'(selectO[1:0])) : dsHalf;
    if (!dsRun || dsResetO) begin
      dsClk = 1'b0;
      dsCnt = 0;
    end else begin
      dsCnt++;
      if (dsCnt >= curHalf) begin
        dsCnt = 0;
        dsClk = ~dsClk;
        if (dsClk) riseCyc.push_back(cyc);
      end
    end
  end

  // Select may only move while both downstream resets are asserted.
  always @(negedge clk) begin
    if (selectO !== prevSel && !(clkResetO && dsResetO)) selBad++;
    prevSel = selectO;
  end

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_accept(input logic [7:0] v, output int a);
    int w;
    w = 0;
    while (!cfgReadyO && w < 2000) begin
      tick();
      w++;
    end
    compared++;
    if (cfgReadyO !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL accept_wait: cfg_ready_o got %b expected 1", cfgReadyO);
    end
    cfgI = v;
    cfgV = 1'b1;
    tick();
    cfgV = 1'b0;
    a = cyc;
  endtask

  // Follows one sequence whose accept edge (or reset release) is at cycle a.
  task automatic follow_seq(input int a, input logic [7:0] expSel, input bit expLock,
                            input string tag, output logic [7:0] offered);
    int clkFall, dsFall, doneAt, readyHits, r4, seen;
    logic [7:0] loadSel;
    logic [1:0] loadRst;
    clkFall = -1; dsFall = -1; doneAt = -1; readyHits = 0; r4 = -1; seen = 0;
    loadSel = 8'hxx;
    loadRst = 2'bxx;
    offered = cfgI;
    riseCyc.delete();
    for (int k = 0; k < 1300; k++) begin
      if (cyc == a + CG_RST) begin
        loadSel = selectO;
        loadRst = {clkResetO, dsResetO};
      end
      if (clkFall < 0 && !clkResetO) clkFall = cyc;
      if (dsFall < 0 && !dsResetO) dsFall = cyc;
      if (doneO) begin
        doneAt = cyc;
        break;
      end
      if (cfgReadyO) readyHits++;
      if (jitterCfg) cfgI = 8'($urandom);
      tick();
    end
    compared++;
    if (doneAt < 0) begin
      mismatched++;
      $display("[TB] FAIL %s_done_seen: no done_o pulse within bound", tag);
      return;
    end
    compared++;
    if (loadSel !== expSel) begin
      mismatched++;
      $display("[TB] FAIL %s_load_sel: got %h expected %h", tag, loadSel, expSel);
    end
    compared++;
    if (loadRst !== 2'b11) begin
      mismatched++;
      $display("[TB] FAIL %s_load_resets: got %b expected 11", tag, loadRst);
    end
    compared++;
    if (clkFall != a + CG_RST + 1) begin
      mismatched++;
      $display("[TB] FAIL %s_clk_release: got cycle %0d expected %0d", tag, clkFall, a + CG_RST + 1);
    end
    compared++;
    if (dsFall != a + CG_RST + 1 + DSD) begin
      mismatched++;
      $display("[TB] FAIL %s_ds_release: got cycle %0d expected %0d", tag, dsFall, a + CG_RST + 1 + DSD);
    end
    compared++;
    if (readyHits != 0) begin
      mismatched++;
      $display("[TB] FAIL %s_ready_busy: got %0d ready cycles expected 0", tag, readyHits);
    end
    if (expLock) begin
      foreach (riseCyc[i]) begin
        if (riseCyc[i] >= dsFall) begin
          seen++;
          if (seen == LOCK_EDGES) r4 = riseCyc[i];
        end
      end
      compared++;
      if (r4 < 0 || doneAt - r4 < 2 || doneAt - r4 > 3) begin
        mismatched++;
        $display("[TB] FAIL %s_lock_time: got done-minus-edge %0d expected 2..3 (edge %0d)", tag, doneAt - r4, r4);
      end
    end else begin
      compared++;
      if (doneAt != a + CG_RST + 1 + DSD + 1 + TIMEOUT) begin
        mismatched++;
        $display("[TB] FAIL %s_timeout_time: got cycle %0d expected %0d", tag, doneAt,
                 a + CG_RST + 1 + DSD + 1 + TIMEOUT);
      end
    end
    compared++;
    if (lockedO !== expLock) begin
      mismatched++;
      $display("[TB] FAIL %s_locked: got %b expected %b", tag, lockedO, expLock);
    end
    compared++;
    if (errO !== !expLock) begin
      mismatched++;
      $display("[TB] FAIL %s_err: got %b expected %b", tag, errO, !expLock);
    end
    compared++;
    if (cfgReadyO !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL %s_ready_after: got %b expected 1", tag, cfgReadyO);
    end
    if (jitterCfg) cfgI = 8'($urandom);
    offered = cfgI;
    tick();
    compared++;
    if (doneO !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s_done_width: got %b expected 0", tag, doneO);
    end
  endtask

  task automatic check_reset_values(input string tag);
    compared++;
    if ({selectO, clkResetO, dsResetO, cfgReadyO, lockedO, errO, doneO} !== {8'h00, 6'b110000}) begin
      mismatched++;
      $display("[TB] FAIL %s: got sel=%h cr=%b dr=%b rdy=%b lk=%b err=%b done=%b expected sel=00 cr=1 dr=1 rdy=0 lk=0 err=0 done=0",
               tag, selectO, clkResetO, dsResetO, cfgReadyO, lockedO, errO, doneO);
    end
  endtask

  task automatic test_reset();
    int a;
    logic [7:0] o;
    resetN = 1'b0;
    dsRun = 1'b1;
    dsHalf = 4;
    repeat (3) tick();
    check_reset_values("reset_values");
    a = cyc;
    resetN = 1'b1;
    follow_seq(a, 8'h00, 1'b1, "boot", o);
  endtask

  task automatic test_accept();
    int a;
    logic [7:0] o;
    do_accept(8'hA5, a);
    compared++;
    if ({clkResetO, dsResetO, cfgReadyO, lockedO} !== 4'b1100) begin
      mismatched++;
      $display("[TB] FAIL accept_next: got cr=%b dr=%b rdy=%b lk=%b expected 1 1 0 0",
               clkResetO, dsResetO, cfgReadyO, lockedO);
    end
    follow_seq(a, 8'hA5, 1'b1, "acc", o);
  endtask

  task automatic test_timeout();
    int a;
    logic [7:0] o;
    dsRun = 1'b0;
    do_accept(8'h3C, a);
    follow_seq(a, 8'h3C, 1'b0, "tmo", o);
    dsRun = 1'b1;
    do_accept(8'h11, a);
    compared++;
    if (errO !== 1'b0 || lockedO !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL err_clear: got err=%b lk=%b expected 0 0", errO, lockedO);
    end
    follow_seq(a, 8'h11, 1'b1, "after_tmo", o);
  endtask

  task automatic test_ignore_cfg();
    int a;
    logic [7:0] off, nxt;
    jitterCfg = 1'b1;
    cfgV = 1'b1;
    cfgI = 8'($urandom);
    off = cfgI;
    tick();
    a = cyc;
    follow_seq(a, off, 1'b1, "jit1", nxt);
    a = cyc;
    off = nxt;
    follow_seq(a, off, 1'b1, "jit2", nxt);
    jitterCfg = 1'b0;
    cfgV = 1'b0;
    a = cyc;
    follow_seq(a, nxt, 1'b1, "jit3", off);
  endtask

  task automatic test_async_reset();
    int a, w;
    logic [7:0] o;
    do_accept(8'h5A, a);
    w = 0;
    while (clkResetO && w < 50) begin
      tick();
      w++;
    end
    compared++;
    if (clkResetO !== 1'b0 || dsResetO !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reach_rel_cg: got cr=%b dr=%b expected 0 1", clkResetO, dsResetO);
    end
    tick();
    tick();
    #2 resetN = 1'b0;
    #1;
    check_reset_values("async_reset_values");
    tick();
    tick();
    check_reset_values("held_reset_values");
    a = cyc;
    resetN = 1'b1;
    follow_seq(a, 8'h00, 1'b1, "reboot", o);
  endtask

  task automatic test_back_to_back();
    int a;
    logic [7:0] o;
    dsSelPeriod = 1'b1;
    for (int v = 0; v < 256; v++) begin
      do_accept(8'(v), a);
      follow_seq(a, 8'(v), 1'b1, $sformatf("sweep%0d", v), o);
    end
    dsSelPeriod = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_accept();
    test_timeout();
    test_ignore_cfg();
    test_async_reset();
    test_back_to_back();
    compared++;
    if (selBad != 0) begin
      mismatched++;
      $display("[TB] FAIL select_stability: got %0d illegal select changes expected 0", selBad);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
